// File: rtl/bru_pkg.sv
// Shared definitions for the branch resolve unit: PC width, fall-through
// offset past the delay slot, and the BTB update record.
package bru_pkg;

  localparam int PC_W = 16;

  // Fall-through skips the jump and its delay slot (two 4-byte words).
  localparam logic [PC_W-1:0] FALL_OFS = 16'd8;

  typedef struct packed {
    logic [PC_W-1:0] from_pc;
    logic [PC_W-1:0] to_pc;
    logic            clear;
  } upd_entry_t;

  // Sequential next-PC for a jump at pc; wraps modulo 2^16.
  function automatic logic [PC_W-1:0] fall_through(input logic [PC_W-1:0] pc);
    return pc + FALL_OFS;
  endfunction

endpackage

// File: rtl/bru_upd_fifo.sv
// Small circular queue of BTB update records. Pointers wrap modulo DEPTH and
// an explicit occupancy count distinguishes full from empty. A push while
// full is accepted only when a pop happens on the same edge.
module bru_upd_fifo
  import bru_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  upd_entry_t push_data,
  input  logic       pop,
  output upd_entry_t head,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  upd_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept;
  logic             pop_ok;

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign accept = push && (!full || pop);
  assign pop_ok = pop && !empty;
  // Idle outputs read as zero so the BTB port never shows stale data.
  assign head   = empty ? '0 : mem[rd_ptr_q];

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop_ok) rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    if (accept && !pop_ok)      count_d = count_q + CNT_W'(1);
    else if (!accept && pop_ok) count_d = count_q - CNT_W'(1);
  end

  // Control state; reset empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until counted as valid.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: checks each jump in ID against the BTB prediction
// captured at fetch, issues a registered one-cycle flush/redirect on a
// mispredict and queues a BTB correction for the write port.
// Optional build macro BRU_STATS_EN adds saturating event counters.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int UPD_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [PC_W-1:0] if_pc,
  input  logic [PC_W-1:0] if_pred_pc,
  input  logic            stall,
  input  logic            id_is_jump,
  input  logic            id_taken,
  input  logic [PC_W-1:0] id_target,
  output logic            flush,
  output logic [PC_W-1:0] redirect_pc,
  output logic            upd_valid,
  input  logic            upd_ready,
  output logic [PC_W-1:0] upd_from_pc,
  output logic [PC_W-1:0] upd_to_pc,
  output logic            upd_clear
`ifdef BRU_STATS_EN
  ,
  output logic [15:0]     branch_cnt,
  output logic [15:0]     mispred_cnt,
  output logic [15:0]     drop_cnt
`endif
);

  logic            id_valid_q;
  logic [PC_W-1:0] id_pc_q;
  logic [PC_W-1:0] id_pred_q;
  logic            flush_q, flush_d;
  logic [PC_W-1:0] redirect_q, redirect_d;
  logic [PC_W-1:0] actual_pc;
  logic            eval;
  logic            mispred;
  upd_entry_t      push_entry;
  upd_entry_t      head;
  logic            q_full, q_empty;
  logic            pop;
  logic            drop;

  // ID valid bit; the fetch latched at the end of a flush cycle is wrong-path.
  always_ff @(posedge clk) begin
    if (rst)         id_valid_q <= 1'b0;
    else if (!stall) id_valid_q <= if_valid && !flush_q;
  end

  // ID PC and predicted next-PC, held while stalled.
  always_ff @(posedge clk) begin
    if (!stall) begin
      id_pc_q   <= if_pc;
      id_pred_q <= if_pred_pc;
    end
  end

  // Resolve the ID jump and build the BTB correction for a mispredict.
  always_comb begin
    eval       = id_valid_q && id_is_jump && !stall;
    actual_pc  = id_taken ? id_target : fall_through(id_pc_q);
    mispred    = eval && (actual_pc != id_pred_q);
    flush_d    = mispred;
    redirect_d = mispred ? actual_pc : '0;
    push_entry.from_pc = id_pc_q;
    push_entry.to_pc   = id_taken ? id_target : '0;
    push_entry.clear   = !id_taken;
  end

  // Registered flush pulse and redirect target, one cycle after evaluation.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_q    <= 1'b0;
      redirect_q <= '0;
    end else begin
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
    end
  end

  assign flush       = flush_q;
  assign redirect_pc = redirect_q;

  assign pop  = !q_empty && upd_ready;
  assign drop = mispred && q_full && !pop;

  bru_upd_fifo #(
    .DEPTH(UPD_DEPTH)
  ) u_upd_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (mispred),
    .push_data(push_entry),
    .pop      (pop),
    .head     (head),
    .full     (q_full),
    .empty    (q_empty)
  );

  assign upd_valid   = !q_empty;
  assign upd_from_pc = head.from_pc;
  assign upd_to_pc   = head.to_pc;
  assign upd_clear   = head.clear;

`ifdef BRU_STATS_EN
  logic [15:0] branch_cnt_q, mispred_cnt_q, drop_cnt_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic en);
    return (en && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;
  endfunction

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      branch_cnt_q  <= sat_inc(branch_cnt_q, eval);
      mispred_cnt_q <= sat_inc(mispred_cnt_q, mispred);
      drop_cnt_q    <= sat_inc(drop_cnt_q, drop);
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
  assign drop_cnt    = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter UPD_DEPTH, default 2, update-queue depth in entries (power of two, >=2).
REQ-002 SHALL have ports: clk  in  1  system clock, rising edge.
REQ-003 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: if_valid  in  1  IF stage holds a fetched instruction.
REQ-005 SHALL have ports: if_pc  in  16  PC of the IF instruction.
REQ-006 SHALL have ports: if_pred_pc  in  16  next-PC the BTB predicted at that fetch.
REQ-007 SHALL have ports: stall  in  1  hold IF/ID, suppress evaluation.
REQ-008 SHALL have ports: id_is_jump, id_taken  in  1 each  decoder result for the ID instruction.
REQ-009 SHALL have ports: id_target  in  16  resolved jump target.
REQ-010 SHALL have ports: flush  out  1  kill the wrong-path fetch, one-cycle pulse.
REQ-011 SHALL have ports: redirect_pc  out  16  correct next-PC, valid while flush=1.
REQ-012 SHALL have ports: upd_valid / upd_ready  out / in  1 each  BTB write handshake.
REQ-013 SHALL have ports: upd_from_pc, upd_to_pc  out  16 each  BTB index PC and new target.
REQ-014 SHALL have ports: upd_clear  out  1  invalidate entry rather than write a target.
REQ-015 SHALL have ports (BRU_STATS_EN only): branch_cnt, mispred_cnt, drop_cnt  out  16 each.

Function
REQ-016 SHALL register if_pc, if_pred_pc, if_valid into an ID register on every non-stalled edge; stall=1 holds it.
REQ-017 SHALL discard (valid=0) the entry captured on the edge ending a flush=1 cycle; the delay slot already in ID is never killed.
REQ-018 SHALL evaluate only when ID valid=1, id_is_jump=1, stall=0; fall-through = id_pc+8 mod 2^16, actual = id_taken ? id_target : fall-through.
REQ-019 SHALL flag mispredict when actual != stored pred_pc, evaluated in cycle N.
REQ-020 SHALL drive flush=1 and redirect_pc=actual in cycle N+1 only; both registered; redirect_pc=0 when flush=0.
REQ-021 SHALL enqueue, on mispredict: taken -> {from=id_pc, to=id_target, clear=0}; not taken -> {from=id_pc, to=0, clear=1}; correct predictions enqueue nothing.
REQ-022 SHALL present the queue head on upd_*; upd_valid=1 iff queue non-empty; pop on upd_valid&&upd_ready.
REQ-023 SHALL hold upd_* stable while upd_valid=1 and upd_ready=0.
REQ-024 SHALL, when full with no pop, drop the new update (flush/redirect still issued); full with pop in same cycle accepts the push.
REQ-025 SHALL keep queue pointers modulo UPD_DEPTH with an explicit count; wrap is seamless.

Reset
REQ-026 SHALL on rst=1 at an edge: ID valid=0, flush=0, redirect_pc=0, queue empty, upd_valid=0, upd_* = 0, counters=0.
REQ-027 SHALL discard queued updates and a pending flush when reset hits mid-operation; rst overrides all inputs.

Configuration
REQ-028 SHALL with BRU_STATS_EN defined: branch_cnt +1 per evaluation, mispred_cnt +1 per mispredict, drop_cnt +1 per dropped update, all saturating at 0xFFFF.
REQ-029 SHALL without BRU_STATS_EN: counter ports and logic absent; all other behaviour identical.

Structure
REQ-030 SHALL place PC width (16), fall-through offset (8), and the update-entry record {from, to, clear} in shared package bru_pkg.
REQ-031 SHALL implement the queue as sub-module bru_upd_fifo (parameterised depth, push/pop/full/empty).

Verification
REQ-032 SHALL cover: pc=0x0010, pred=0x0040, taken, target=0x0040 -> no flush, no update.
REQ-033 SHALL cover: pc=0x0010, pred=0x0018, taken, target=0x0080 -> N+1 flush=1, redirect=0x0080; update {0x0010,0x0080,0}.
REQ-034 SHALL cover: pc=0xFFFC, pred=0x0100, not taken -> redirect=0x0004 (wrap); update {0xFFFC,0,1}.
REQ-035 SHALL cover: upd_ready=0, three mispredicts, depth 2 -> first two held stable, third dropped, drop_cnt=1; ready=1 drains in order.
REQ-036 SHALL cover: mispredict with stall=1 for 3 cycles -> exactly one flush after stall drops; rst during flush cycle -> flush=0, queue empty next cycle.
